// File: rtl/mmc1_gen_mapper.sv
// Parameterised MMC1-style mapper: serial register port, PRG/CHR bank
// selection, PRG-RAM window decode and nametable mirroring.
module mmc1_gen_mapper #(
    parameter int SHIFT_LEN  = 5,
    parameter int PRG_BANK_W = 4,
    parameter int CHR_BANK_W = 5,
    parameter int MMC1A      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        enable,
    input  logic [15:0] prg_ain,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    input  logic [13:0] chr_ain,
    input  logic        cfg_hard_mirror,
    input  logic        cfg_ram_present,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    output logic [21:0] chr_aout,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic        ram_en,
    output logic        reg_upd,
    output logic [1:0]  reg_idx,
    output logic [2:0]  shift_cnt
);

    localparam logic [2:0] LAST_BIT = 3'(SHIFT_LEN - 1);
    localparam logic [4:0] CTRL_RST = 5'b01100;

    logic [4:0]           control_q, control_d;
    logic [SHIFT_LEN-1:0] chr0_q, chr0_d;
    logic [SHIFT_LEN-1:0] chr1_q, chr1_d;
    logic [SHIFT_LEN-1:0] prg_q, prg_d;
    logic [SHIFT_LEN-2:0] shift_q, shift_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 wf_q, wf_d;
    logic                 reg_upd_q, reg_upd_d;
    logic [1:0]           reg_idx_q, reg_idx_d;
    logic [SHIFT_LEN-1:0] load_val;

    // Serial port: write filter, reset command, bit collection and register load.
    always_comb begin
        control_d = control_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        wf_d      = wf_q;
        reg_upd_d = 1'b0;
        reg_idx_d = reg_idx_q;
        load_val  = {prg_din[0], shift_q};
        if (!enable) begin
            control_d = CTRL_RST;
            chr0_d    = '0;
            chr1_d    = '0;
            prg_d     = '0;
            shift_d   = '0;
            cnt_d     = '0;
            wf_d      = 1'b0;
            reg_idx_d = '0;
        end else if (ce) begin
            if (!prg_write) begin
                wf_d = 1'b0;
            end else if (prg_ain[15] && !wf_q) begin
                wf_d = 1'b1;
                if (prg_din[7]) begin
                    cnt_d     = '0;
                    shift_d   = '0;
                    control_d = control_q | CTRL_RST;
                end else if (cnt_q == LAST_BIT) begin
                    case (prg_ain[14:13])
                        2'd0:    control_d = load_val[4:0];
                        2'd1:    chr0_d    = load_val;
                        2'd2:    chr1_d    = load_val;
                        default: prg_d     = load_val;
                    endcase
                    cnt_d     = '0;
                    shift_d   = '0;
                    reg_upd_d = 1'b1;
                    reg_idx_d = prg_ain[14:13];
                end else begin
                    for (int k = 0; k < SHIFT_LEN - 1; k++) begin
                        if (cnt_q == 3'(k)) shift_d[k] = prg_din[0];
                    end
                    cnt_d = cnt_q + 3'd1;
                end
            end
        end
    end

    // State registers; reg_upd is written every edge so it only ever pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control_q <= CTRL_RST;
            chr0_q    <= '0;
            chr1_q    <= '0;
            prg_q     <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            wf_q      <= 1'b0;
            reg_upd_q <= 1'b0;
            reg_idx_q <= '0;
        end else begin
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            wf_q      <= wf_d;
            reg_upd_q <= reg_upd_d;
            reg_idx_q <= reg_idx_d;
        end
    end

    // Bank registers resized to the bank widths; missing high bits read as zero.
    logic [PRG_BANK_W-1:0] prg_x;
    logic [CHR_BANK_W-1:0] chr0_x, chr1_x;
    logic [PRG_BANK_W-1:0] prgsel;
    logic [CHR_BANK_W-1:0] chrsel;
    logic                  ram_window;
    logic [1:0]            mirror;
    logic                  unused_bits;

    assign prg_x  = PRG_BANK_W'(prg_q);
    assign chr0_x = CHR_BANK_W'(chr0_q);
    assign chr1_x = CHR_BANK_W'(chr1_q);

    // PRG bank select: 32 KB mode, fixed-first or fixed-last 16 KB modes.
    always_comb begin
        case (control_q[3:2])
            2'b10:   prgsel = prg_ain[14] ? prg_x : '0;
            2'b11:   prgsel = prg_ain[14] ? '1 : prg_x;
            default: prgsel = {prg_x[PRG_BANK_W-1:1], prg_ain[14]};
        endcase
    end

    // CHR bank select: 8 KB mode or two independent 4 KB banks.
    always_comb begin
        if (control_q[4]) chrsel = chr_ain[12] ? chr1_x : chr0_x;
        else              chrsel = {chr0_x[CHR_BANK_W-1:1], chr_ain[12]};
    end

    // Nametable A10 from mirroring mode; hard-wired boards force vertical.
    always_comb begin
        mirror = cfg_hard_mirror ? 2'd2 : control_q[1:0];
        case (mirror)
            2'd0:    vram_a10 = 1'b0;
            2'd1:    vram_a10 = 1'b1;
            2'd2:    vram_a10 = chr_ain[10];
            default: vram_a10 = chr_ain[11];
        endcase
    end

    assign ram_window = (prg_ain[15:13] == 3'b011);
    assign ram_en     = cfg_ram_present & ((MMC1A != 0) | ~prg_q[4]);
    assign prg_allow  = (prg_ain[15] & ~prg_write) | (ram_window & ram_en);
    assign prg_aout   = ram_window
        ? {7'b1111000, chrsel[3], chrsel[2], prg_ain[12:0]}
        : {{(22 - 15 - PRG_BANK_W){1'b0}}, chrsel[4], prgsel, prg_ain[13:0]};
    assign chr_aout   = {1'b1, 21'd0}
                      | ({{(22 - CHR_BANK_W){1'b0}}, chrsel} << 12)
                      | {10'd0, chr_ain[11:0]};
    assign vram_ce    = chr_ain[13];
    assign reg_upd    = reg_upd_q;
    assign reg_idx    = reg_idx_q;
    assign shift_cnt  = cnt_q;
    assign unused_bits = ^prg_din[6:1];

endmodule
